// File: rtl/cmp_share_arbiter.sv
// Shares one 32-bit not-equal comparator between two requesters behind a one-deep result buffer.
// Define CMP_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module cmp_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_neq,
  output logic             resp_src,
  output logic [TAG_W-1:0] resp_tag
);

  logic             slot_free;
  logic             sel;
  logic             accept;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [TAG_W-1:0] op_tag;
  logic             neq;

`ifndef CMP_FIXED_PRIO_EN
  logic last_grant;
`endif

  assign slot_free = !resp_valid || resp_ready;

  // sel picks the winner from the valids alone, so ready never depends on operands.
`ifdef CMP_FIXED_PRIO_EN
  assign sel = !req0_valid;
`else
  assign sel = (req0_valid && req1_valid) ? !last_grant : !req0_valid;
`endif

  assign req0_ready = slot_free && req0_valid && !sel;
  assign req1_ready = slot_free && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;

  assign op_a   = sel ? req1_a   : req0_a;
  assign op_b   = sel ? req1_b   : req0_b;
  assign op_tag = sel ? req1_tag : req0_tag;
  assign neq    = |(op_a ^ op_b);

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_neq   <= 1'b0;
      resp_src   <= 1'b0;
      resp_tag   <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_neq   <= neq;
      resp_src   <= sel;
      resp_tag   <= op_tag;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifndef CMP_FIXED_PRIO_EN
  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= sel;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_cmp_share_arbiter;

  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             resp_valid, resp_ready, resp_neq, resp_src;
  logic [TAG_W-1:0] resp_tag;

  int checks = 0;
  int errors = 0;

  // Reference model state: the buffered result and which requester is preferred next.
  bit             m_valid, m_neq, m_src, m_pref;
  bit [TAG_W-1:0] m_tag;

  cmp_share_arbiter #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_neq(resp_neq), .resp_src(resp_src), .resp_tag(resp_tag)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    req0_valid = v; req0_a = a; req0_b = b; req0_tag = t;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    req1_valid = v; req1_a = a; req1_b = b; req1_tag = t;
  endtask

  task automatic idle();
    drive0(1'b0, 32'd0, 32'd0, '0);
    drive1(1'b0, 32'd0, 32'd0, '0);
  endtask

  task automatic do_reset();
    idle();
    resp_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_neq = 0; m_src = 0; m_tag = '0; m_pref = 0;
  endtask

  // Expected readies from the arbitration rules: free slot, then the winner among valid requesters.
  task automatic model_ready(output bit e0, output bit e1);
    bit slot, win;
    slot = !m_valid || resp_ready;
    e0 = 0; e1 = 0;
    if (slot) begin
      if (req0_valid && req1_valid) begin
`ifdef CMP_FIXED_PRIO_EN
        win = 0;
`else
        win = m_pref;
`endif
        e0 = (win == 0); e1 = (win == 1);
      end else begin
        e0 = req0_valid; e1 = req1_valid;
      end
    end
  endtask

  task automatic model_advance(input bit e0, input bit e1);
    if (e0) begin
      m_valid = 1; m_neq = (req0_a != req0_b); m_src = 0; m_tag = req0_tag; m_pref = 1;
    end else if (e1) begin
      m_valid = 1; m_neq = (req1_a != req1_b); m_src = 1; m_tag = req1_tag; m_pref = 0;
    end else if (m_valid && resp_ready) begin
      m_valid = 0;
    end
  endtask

  function automatic logic [31:0] rand_b(input logic [31:0] a);
    int r;
    r = $urandom_range(0, 2);
    if (r == 0) return a;
    if (r == 1) return a ^ (32'd1 << $urandom_range(0, 31));
    return $urandom;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle();
    resp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checks += 4;
    if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", resp_valid); end
    if (resp_neq !== 1'b0)   begin errors++; $display("[TB] FAIL reset_neq: got %0b expected 0", resp_neq); end
    if (resp_src !== 1'b0)   begin errors++; $display("[TB] FAIL reset_src: got %0b expected 0", resp_src); end
    if (resp_tag !== '0)     begin errors++; $display("[TB] FAIL reset_tag: got %0h expected 0", resp_tag); end
  endtask

  task automatic test_single();
    resp_ready = 1'b1;
    drive0(1'b1, 32'h0000_00FF, 32'h0000_00FF, 4'd3);
    #1;
    checks += 2;
    if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready0: got %0b expected 1", req0_ready); end
    if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready1: got %0b expected 0", req1_ready); end
    tick();
    idle();
    checks += 4;
    if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0b expected 1", resp_valid); end
    if (resp_neq !== 1'b0)   begin errors++; $display("[TB] FAIL single_neq: got %0b expected 0", resp_neq); end
    if (resp_src !== 1'b0)   begin errors++; $display("[TB] FAIL single_src: got %0b expected 0", resp_src); end
    if (resp_tag !== 4'd3)   begin errors++; $display("[TB] FAIL single_tag: got %0h expected 3", resp_tag); end
    tick();
    checks += 2;
    if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain: got %0b expected 0", resp_valid); end
    if (resp_tag !== 4'd3)   begin errors++; $display("[TB] FAIL single_hold_tag: got %0h expected 3", resp_tag); end
  endtask

  task automatic test_contention();
    int g;
    do_reset();
    drive0(1'b1, 32'd1, 32'd2, 4'hA);
    drive1(1'b1, 32'd5, 32'd5, 4'h5);
    for (int i = 0; i < 4; i++) begin
`ifdef CMP_FIXED_PRIO_EN
      g = 0;
`else
      g = i % 2;
`endif
      #1;
      checks += 2;
      if (req0_ready !== (g == 0)) begin errors++; $display("[TB] FAIL rr_ready0[%0d]: got %0b expected %0b", i, req0_ready, g == 0); end
      if (req1_ready !== (g == 1)) begin errors++; $display("[TB] FAIL rr_ready1[%0d]: got %0b expected %0b", i, req1_ready, g == 1); end
      tick();
      checks += 4;
      if (resp_valid !== 1'b1)    begin errors++; $display("[TB] FAIL rr_valid[%0d]: got %0b expected 1", i, resp_valid); end
      if (resp_src !== g[0])      begin errors++; $display("[TB] FAIL rr_src[%0d]: got %0b expected %0d", i, resp_src, g); end
      if (resp_neq !== (g == 0))  begin errors++; $display("[TB] FAIL rr_neq[%0d]: got %0b expected %0b", i, resp_neq, g == 0); end
      if (resp_tag !== (g == 0 ? 4'hA : 4'h5)) begin errors++; $display("[TB] FAIL rr_tag[%0d]: got %0h", i, resp_tag); end
    end
    idle();
    tick();
  endtask

  task automatic test_stall();
    resp_ready = 1'b1;
    drive1(1'b1, 32'h8000_0000, 32'h0, 4'd6);
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_acc1: got %0b expected 1", req1_ready); end
    tick();
    drive1(1'b0, 32'd0, 32'd0, '0);
    drive0(1'b1, 32'd7, 32'd7, 4'd9);
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 5;
      if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready0[%0d]: got %0b expected 0", i, req0_ready); end
      if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %0b expected 1", i, resp_valid); end
      if (resp_neq !== 1'b1)   begin errors++; $display("[TB] FAIL stall_neq[%0d]: got %0b expected 1", i, resp_neq); end
      if (resp_src !== 1'b1)   begin errors++; $display("[TB] FAIL stall_src[%0d]: got %0b expected 1", i, resp_src); end
      if (resp_tag !== 4'd6)   begin errors++; $display("[TB] FAIL stall_tag[%0d]: got %0h expected 6", i, resp_tag); end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready0: got %0b expected 1", req0_ready); end
    tick();
    idle();
    checks += 4;
    if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL release_valid: got %0b expected 1", resp_valid); end
    if (resp_src !== 1'b0)   begin errors++; $display("[TB] FAIL release_src: got %0b expected 0", resp_src); end
    if (resp_neq !== 1'b0)   begin errors++; $display("[TB] FAIL release_neq: got %0b expected 0", resp_neq); end
    if (resp_tag !== 4'd9)   begin errors++; $display("[TB] FAIL release_tag: got %0h expected 9", resp_tag); end
    tick();
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive0(1'b1, 32'(i * 3), 32'(i * 3 + (i % 2)), 4'(i));
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %0b expected 1", i, req0_ready); end
      tick();
      checks += 3;
      if (resp_valid !== 1'b1)     begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %0b expected 1", i, resp_valid); end
      if (resp_tag !== 4'(i))      begin errors++; $display("[TB] FAIL b2b_tag[%0d]: got %0h expected %0h", i, resp_tag, i); end
      if (resp_neq !== (i % 2 == 1)) begin errors++; $display("[TB] FAIL b2b_neq[%0d]: got %0b expected %0b", i, resp_neq, i % 2 == 1); end
    end
    idle();
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got %0b expected 0", resp_valid); end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    drive0(1'b1, 32'd1, 32'd3, 4'hC);
    tick();
    idle();
    tick();
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_stalled: got %0b expected 1", resp_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 4;
    if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %0b expected 0", resp_valid); end
    if (resp_neq !== 1'b0)   begin errors++; $display("[TB] FAIL mid_neq: got %0b expected 0", resp_neq); end
    if (resp_src !== 1'b0)   begin errors++; $display("[TB] FAIL mid_src: got %0b expected 0", resp_src); end
    if (resp_tag !== '0)     begin errors++; $display("[TB] FAIL mid_tag: got %0h expected 0", resp_tag); end
    resp_ready = 1'b1;
    drive0(1'b1, 32'd4, 32'd4, 4'd1);
    drive1(1'b1, 32'd4, 32'd5, 4'd2);
    #1;
    checks += 2;
    if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_first0: got %0b expected 1", req0_ready); end
    if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_first1: got %0b expected 0", req1_ready); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_sweep();
    bit exp;
    resp_ready = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      if (k < 32) drive0(1'b1, 32'd0, 32'd1 << k, 4'(k));
      else        drive0(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'(k));
      exp = (k < 32);
      tick();
      checks++;
      if (resp_neq !== exp) begin errors++; $display("[TB] FAIL sweep_neq[%0d]: got %0b expected %0b", k, resp_neq, exp); end
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    bit e0, e1;
    bit acc0 = 0, acc1 = 0;
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a = $urandom; req0_b = rand_b(req0_a); req0_tag = 4'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a = $urandom; req1_b = rand_b(req1_a); req1_tag = 4'($urandom);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_ready(e0, e1);
      checks += 2;
      if (req0_ready !== e0) begin errors++; $display("[TB] FAIL rnd_ready0[%0d]: got %0b expected %0b", c, req0_ready, e0); end
      if (req1_ready !== e1) begin errors++; $display("[TB] FAIL rnd_ready1[%0d]: got %0b expected %0b", c, req1_ready, e1); end
      acc0 = e0; acc1 = e1;
      model_advance(e0, e1);
      tick();
      checks += 4;
      if (resp_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %0b expected %0b", c, resp_valid, m_valid); end
      if (resp_neq !== m_neq)     begin errors++; $display("[TB] FAIL rnd_neq[%0d]: got %0b expected %0b", c, resp_neq, m_neq); end
      if (resp_src !== m_src)     begin errors++; $display("[TB] FAIL rnd_src[%0d]: got %0b expected %0b", c, resp_src, m_src); end
      if (resp_tag !== m_tag)     begin errors++; $display("[TB] FAIL rnd_tag[%0d]: got %0h expected %0h", c, resp_tag, m_tag); end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
